// File: rtl/sequence_generator_if.sv
// Parallel-load / serial-out bus between a pattern source and the sequence generator.
interface sequence_generator_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  localparam int unsigned LEN_W = $clog2(WIDTH + 1);

  logic             load;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] rpt;     // additional passes after the first
  logic             ready;
  logic             a;
  logic             valid;
  logic             done;

  modport master (
    output load, abort, pattern, len, rpt,
    input  ready, a, valid, done
  );

  modport slave (
    input  load, abort, pattern, len, rpt,
    output ready, a, valid, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: replays a captured pattern MSB-first, rpt+1 times,
// with GAP idle cycles between passes and a one-cycle done pulse at the end.
module sequence_generator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 2
) (
  input logic                 clk,
  input logic                 rst,
  sequence_generator_if.slave sif
);
  localparam int unsigned LEN_W  = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PASS_W = CNT_W + 1;
  localparam int unsigned GAP_W  = 8;
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pattern_q, pattern_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              ready_q, ready_d;
  logic              a_q, a_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  assign sif.ready = ready_q;
  assign sif.a     = a_q;
  assign sif.valid = valid_q;
  assign sif.done  = done_q;

  // State, captured transfer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      passes_q  <= '0;
      gap_q     <= '0;
      ready_q   <= 1'b1;
      a_q       <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      passes_q  <= passes_d;
      gap_q     <= gap_d;
      ready_q   <= ready_d;
      a_q       <= a_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  // Next state, counters, and the output values that follow the next state
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    idx_d     = idx_q;
    passes_d  = passes_q;
    gap_d     = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (sif.load && !sif.abort) begin
          pattern_d = sif.pattern;
          len_d     = (sif.len == '0 || sif.len > WIDTH_L) ? WIDTH_L : sif.len;
          idx_d     = IDX_W'(len_d - LEN_W'(1));
          passes_d  = PASS_W'(sif.rpt) + PASS_W'(1);
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sif.abort) begin
          state_d = ST_IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (passes_q > PASS_W'(1)) begin
          passes_d = passes_q - PASS_W'(1);
          if (GAP > 0) begin
            gap_d   = GAP_W'(GAP - 1);
            state_d = ST_GAP;
          end else begin
            idx_d = IDX_W'(len_q - LEN_W'(1));
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        if (sif.abort) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          idx_d   = IDX_W'(len_q - LEN_W'(1));
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_SEND);
    a_d     = (state_d == ST_SEND) ? pattern_d[idx_d] : 1'b0;
    done_d  = (state_d == ST_DONE);
  end
endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: one GAP=2 instance and one GAP=0 instance
// share the same stimulus.
module tb_sequence_generator;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sequence_generator_if #(.WIDTH(8), .CNT_W(4)) g2 ();
  sequence_generator_if #(.WIDTH(8), .CNT_W(4)) g0 ();

  assign g0.load    = g2.load;
  assign g0.abort   = g2.abort;
  assign g0.pattern = g2.pattern;
  assign g0.len     = g2.len;
  assign g0.rpt     = g2.rpt;

  sequence_generator #(.WIDTH(8), .CNT_W(4), .GAP(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .sif (g2.slave)
  );

  sequence_generator #(.WIDTH(8), .CNT_W(4), .GAP(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .sif (g0.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a load for one edge; returns 1ns after that edge (edge N).
  task automatic start(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    g2.pattern = p;
    g2.len     = l;
    g2.rpt     = r;
    g2.load    = 1'b1;
    step();
    g2.load    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (g2.ready !== 1'b1 || g2.valid !== 1'b0 || g2.a !== 1'b0 || g2.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: ready=%b valid=%b a=%b done=%b, want 1 0 0 0",
               g2.ready, g2.valid, g2.a, g2.done);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (g2.ready !== 1'b1 || g2.valid !== 1'b0 || g2.a !== 1'b0 || g2.done !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: ready=%b valid=%b a=%b done=%b, want 1 0 0 0",
                 i, g2.ready, g2.valid, g2.a, g2.done);
      end
    end
  endtask

  task automatic test_single_pass();
    logic [7:0] exp_a;
    exp_a = 8'hE7;
    start(8'hE7, 4'd8, 4'd0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (g2.valid !== 1'b1 || g2.a !== exp_a[7-i] || g2.ready !== 1'b0) begin
        bad++;
        $display("FAIL single_bit[%0d]: valid=%b a=%b ready=%b, want 1 %b 0",
                 i, g2.valid, g2.a, g2.ready, exp_a[7-i]);
      end
      step();
    end
    total++;
    if (g2.done !== 1'b1 || g2.valid !== 1'b0 || g2.ready !== 1'b0) begin
      bad++;
      $display("FAIL single_done: done=%b valid=%b ready=%b, want 1 0 0", g2.done, g2.valid, g2.ready);
    end
    step();
    total++;
    if (g2.done !== 1'b0 || g2.ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready: done=%b ready=%b, want 0 1", g2.done, g2.ready);
    end
  endtask

  task automatic test_repeat_gap();
    logic [12:0] exp_v;
    logic [12:0] exp_a;
    int          nvalid;
    exp_v  = 13'b1110011100111;
    exp_a  = 13'b1010010100101;
    nvalid = 0;
    start(8'h05, 4'd3, 4'd2);
    for (int i = 0; i < 13; i++) begin
      if (g2.valid === 1'b1) nvalid++;
      total++;
      if (g2.valid !== exp_v[12-i] || g2.a !== exp_a[12-i] || g2.done !== 1'b0) begin
        bad++;
        $display("FAIL repeat_cycle[%0d]: valid=%b a=%b done=%b, want %b %b 0",
                 i, g2.valid, g2.a, g2.done, exp_v[12-i], exp_a[12-i]);
      end
      step();
    end
    total++;
    if (g2.done !== 1'b1) begin
      bad++;
      $display("FAIL repeat_done: done=%b, want 1", g2.done);
    end
    total++;
    if (nvalid != 9) begin
      bad++;
      $display("FAIL repeat_valid_count: got %0d, want 9", nvalid);
    end
    step();
  endtask

  task automatic test_len_clamp();
    logic [7:0] exp_a;
    logic [3:0] lens [2];
    exp_a   = 8'h81;
    lens[0] = 4'd0;
    lens[1] = 4'd12;
    for (int k = 0; k < 2; k++) begin
      start(8'h81, lens[k], 4'd0);
      for (int i = 0; i < 8; i++) begin
        total++;
        if (g2.valid !== 1'b1 || g2.a !== exp_a[7-i]) begin
          bad++;
          $display("FAIL clamp_len%0d_bit[%0d]: valid=%b a=%b, want 1 %b",
                   lens[k], i, g2.valid, g2.a, exp_a[7-i]);
        end
        step();
      end
      total++;
      if (g2.done !== 1'b1 || g2.valid !== 1'b0) begin
        bad++;
        $display("FAIL clamp_len%0d_done: done=%b valid=%b, want 1 0", lens[k], g2.done, g2.valid);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a;
    exp_a = 8'h81;
    start(8'h81, 4'd8, 4'd1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (g0.valid !== 1'b1 || g0.a !== exp_a[7-(i%8)]) begin
        bad++;
        $display("FAIL b2b_bit[%0d]: valid=%b a=%b, want 1 %b", i, g0.valid, g0.a, exp_a[7-(i%8)]);
      end
      step();
    end
    total++;
    if (g0.done !== 1'b1 || g0.valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done: done=%b valid=%b, want 1 0", g0.done, g0.valid);
    end
    // let the GAP=2 instance finish its own 19-cycle run
    for (int i = 0; i < 6; i++) step();
    total++;
    if (g2.ready !== 1'b1 || g0.ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle: ready=%b/%b, want 1/1", g2.ready, g0.ready);
    end
  endtask

  task automatic test_busy_abort();
    logic [7:0] exp_a;
    exp_a = 8'hA5;
    start(8'hA5, 4'd8, 4'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g2.valid !== 1'b1 || g2.a !== exp_a[7-i]) begin
        bad++;
        $display("FAIL busy_bit[%0d]: valid=%b a=%b, want 1 %b", i, g2.valid, g2.a, exp_a[7-i]);
      end
      if (i == 1) begin
        g2.pattern = 8'hFF;
        g2.len     = 4'd2;
        g2.load    = 1'b1;
      end else begin
        g2.load = 1'b0;
      end
      if (i == 3) g2.abort = 1'b1;
      step();
    end
    g2.abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (g2.valid !== 1'b0 || g2.ready !== 1'b1 || g2.done !== 1'b0 || g2.a !== 1'b0) begin
        bad++;
        $display("FAIL abort_idle[%0d]: valid=%b ready=%b done=%b a=%b, want 0 1 0 0",
                 i, g2.valid, g2.ready, g2.done, g2.a);
      end
      step();
    end
    g2.pattern = 8'hFF;
    g2.len     = 4'd8;
    g2.load    = 1'b1;
    g2.abort   = 1'b1;
    step();
    g2.load  = 1'b0;
    g2.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (g2.valid !== 1'b0 || g2.ready !== 1'b1) begin
        bad++;
        $display("FAIL load_abort_idle[%0d]: valid=%b ready=%b, want 0 1", i, g2.valid, g2.ready);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [7:0] exp_a;
    start(8'h05, 4'd3, 4'd2);
    step();
    step();
    step();
    total++;
    if (g2.valid !== 1'b0 || g2.ready !== 1'b0) begin
      bad++;
      $display("FAIL gap_entry: valid=%b ready=%b, want 0 0", g2.valid, g2.ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (g2.ready !== 1'b1 || g2.valid !== 1'b0 || g2.a !== 1'b0 || g2.done !== 1'b0) begin
      bad++;
      $display("FAIL rst_gap: ready=%b valid=%b a=%b done=%b, want 1 0 0 0",
               g2.ready, g2.valid, g2.a, g2.done);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (g2.done !== 1'b0 || g2.valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_gap_quiet[%0d]: done=%b valid=%b, want 0 0", i, g2.done, g2.valid);
      end
      step();
    end
    exp_a = 8'hC3;
    start(8'hC3, 4'd8, 4'd0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (g2.valid !== 1'b1 || g2.a !== exp_a[7-i]) begin
        bad++;
        $display("FAIL after_rst_bit[%0d]: valid=%b a=%b, want 1 %b", i, g2.valid, g2.a, exp_a[7-i]);
      end
      step();
    end
    total++;
    if (g2.done !== 1'b1) begin
      bad++;
      $display("FAIL after_rst_done: done=%b, want 1", g2.done);
    end
    step();
  endtask

  initial begin
    rst        = 1'b1;
    g2.load    = 1'b0;
    g2.abort   = 1'b0;
    g2.pattern = '0;
    g2.len     = '0;
    g2.rpt     = '0;
    test_reset();
    test_single_pass();
    step();
    test_repeat_gap();
    step();
    test_len_clamp();
    step();
    test_back_to_back();
    test_busy_abort();
    test_reset_mid_gap();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
